// File: rtl/ram_host_arbiter.sv
// Two-host round-robin arbiter in front of the single-port data RAM.
// Out-of-window accesses are answered locally with an error response one cycle after grant.
module ram_host_arbiter #(
  parameter int unsigned Depth    = 128,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        h0_req_i,
  input  logic        h0_we_i,
  input  logic [3:0]  h0_be_i,
  input  logic [31:0] h0_addr_i,
  input  logic [31:0] h0_wdata_i,
  output logic        h0_gnt_o,
  output logic        h0_rvalid_o,
  output logic        h0_err_o,
  output logic [31:0] h0_rdata_o,

  input  logic        h1_req_i,
  input  logic        h1_we_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h1_addr_i,
  input  logic [31:0] h1_wdata_i,
  output logic        h1_gnt_o,
  output logic        h1_rvalid_o,
  output logic        h1_err_o,
  output logic [31:0] h1_rdata_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [31:0] Window = 32'(4 * Depth);

  // r_last = 1 means host 1 received the most recent grant.
  logic        r_last;
  logic        r_pend;
  logic        r_id;
  logic        r_err;

  logic [31:0] w_off0;
  logic [31:0] w_off1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic        w_sel_in_range;
  logic        w_resp_ok;

  // Unsigned wrap makes addresses below BaseAddr land far outside the window.
  assign w_off0 = h0_addr_i - BaseAddr;
  assign w_off1 = h1_addr_i - BaseAddr;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_sel_in_range = 1'b0;
    ram_we_o       = h0_we_i;
    ram_be_o       = h0_be_i;
    ram_addr_o     = w_off0;
    ram_wdata_o    = h0_wdata_i;

    if (!rst_i) begin
      w_gnt0 = h0_req_i && (!h1_req_i || r_last);
      w_gnt1 = h1_req_i && (!h0_req_i || !r_last);
    end

    if (w_gnt1) begin
      w_sel_in_range = (w_off1 < Window);
      ram_we_o       = h1_we_i;
      ram_be_o       = h1_be_i;
      ram_addr_o     = w_off1;
      ram_wdata_o    = h1_wdata_i;
    end else if (w_gnt0) begin
      w_sel_in_range = (w_off0 < Window);
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign h0_gnt_o  = w_gnt0;
  assign h1_gnt_o  = w_gnt1;
  assign ram_req_o = w_any_gnt & w_sel_in_range;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
      r_pend <= 1'b0;
      r_id   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_any_gnt) r_last <= w_gnt1;
      r_pend <= w_any_gnt;
      r_id   <= w_gnt1;
      r_err  <= w_any_gnt & ~w_sel_in_range;
    end
  end

  // Reset in the response cycle drops the in-flight response.
  assign w_resp_ok = r_pend & ~rst_i;

  always_comb begin
    h0_rvalid_o = 1'b0;
    h0_err_o    = 1'b0;
    h0_rdata_o  = '0;
    h1_rvalid_o = 1'b0;
    h1_err_o    = 1'b0;
    h1_rdata_o  = '0;

    if (w_resp_ok) begin
      if (!r_id) begin
        h0_rvalid_o = r_err | ram_rvalid_i;
        h0_err_o    = r_err;
        h0_rdata_o  = r_err ? 32'h0 : ram_rdata_i;
      end else begin
        h1_rvalid_o = r_err | ram_rvalid_i;
        h1_err_o    = r_err;
        h1_rdata_o  = r_err ? 32'h0 : ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Directed bench for ram_host_arbiter with a behavioural single-port RAM
// answering one cycle after each request.
module tb_ram_host_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        h0_req = 1'b0, h0_we = 1'b0;
  logic [3:0]  h0_be = 4'hF;
  logic [31:0] h0_addr = '0, h0_wdata = '0;
  logic        h0_gnt, h0_rvalid, h0_err;
  logic [31:0] h0_rdata;

  logic        h1_req = 1'b0, h1_we = 1'b0;
  logic [3:0]  h1_be = 4'hF;
  logic [31:0] h1_addr = '0, h1_wdata = '0;
  logic        h1_gnt, h1_rvalid, h1_err;
  logic [31:0] h1_rdata;

  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;

  logic        ram_rvalid_q = 1'b0;
  logic [31:0] ram_rdata_q  = '0;
  logic        force_rvalid = 1'b0;
  logic [31:0] mem [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_host_arbiter #(.Depth(128), .BaseAddr(32'h0)) dut (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
    .h0_wdata_i(h0_wdata), .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid),
    .h0_err_o(h0_err), .h0_rdata_o(h0_rdata),
    .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
    .h1_wdata_i(h1_wdata), .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid),
    .h1_err_o(h1_err), .h1_rdata_o(h1_rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
  );

  // RAM model: one-cycle read latency, byte-enabled writes.
  always_ff @(posedge clk) begin
    ram_rvalid_q <= ram_req;
    if (ram_req) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata_q <= mem[ram_addr[8:2]];
      end
    end
  end

  assign ram_rvalid = ram_rvalid_q | force_rvalid;
  assign ram_rdata  = ram_rdata_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    h0_req = req; h0_we = we; h0_be = be; h0_addr = addr; h0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    h1_req = req; h1_we = we; h1_be = be; h1_addr = addr; h1_wdata = wdata;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
  endtask

  // Each cycle: inputs change at the falling edge, outputs checked 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;

    // Reset: requests are ignored while rst is high.
    next_cycle();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    drive1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    #1;
    check("rst_gnt0", h0_gnt, 1'b0);
    check("rst_gnt1", h1_gnt, 1'b0);
    check("rst_ramreq", ram_req, 1'b0);
    next_cycle();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_rv0", h0_rvalid, 1'b0);
    check("post_rst_rv1", h1_rvalid, 1'b0);
    check("post_rst_err0", h0_err, 1'b0);

    // Single read of word 5.
    next_cycle();
    drive0(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    #1;
    check("rd_gnt0", h0_gnt, 1'b1);
    check("rd_gnt1", h1_gnt, 1'b0);
    check("rd_ramreq", ram_req, 1'b1);
    check("rd_ramaddr", ram_addr, 32'h14);
    check("rd_ramwe", ram_we, 1'b0);
    next_cycle();
    idle();
    #1;
    check("rd_rv0", h0_rvalid, 1'b1);
    check("rd_rdata0", h0_rdata, 32'hDEADBEEF);
    check("rd_err0", h0_err, 1'b0);
    check("rd_rv1", h1_rvalid, 1'b0);

    // Contention right after reset: h0 wins first, then strict alternation.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      drive0(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      drive1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
      #1;
      check($sformatf("cont%0d_gnt0", k), h0_gnt, (k % 2 == 0));
      check($sformatf("cont%0d_gnt1", k), h1_gnt, (k % 2 == 1));
      check($sformatf("cont%0d_rv0", k), h0_rvalid, (k > 0 && k % 2 == 1));
      check($sformatf("cont%0d_rv1", k), h1_rvalid, (k > 0 && k % 2 == 0));
      if (k % 2 == 1) check($sformatf("cont%0d_rdata0", k), h0_rdata, 32'hDEADBEEF);
    end
    next_cycle();
    idle();
    #1;
    check("cont_end_rv1", h1_rvalid, 1'b1);
    check("cont_end_rdata1", h1_rdata, 32'h0);
    check("cont_end_rv0", h0_rvalid, 1'b0);

    // Byte write from h1 to word 2, then read back.
    next_cycle();
    drive1(1'b1, 1'b1, 4'b0100, 32'h8, 32'h11223344);
    #1;
    check("bw_gnt1", h1_gnt, 1'b1);
    check("bw_ramwe", ram_we, 1'b1);
    check("bw_rambe", ram_be, 4'b0100);
    check("bw_wdata", ram_wdata, 32'h11223344);
    next_cycle();
    drive1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    #1;
    check("bw_wr_rv1", h1_rvalid, 1'b1);
    check("bw_wr_err1", h1_err, 1'b0);
    check("bw_rd_gnt1", h1_gnt, 1'b1);
    next_cycle();
    idle();
    #1;
    check("bw_rd_rv1", h1_rvalid, 1'b1);
    check("bw_rd_rdata1", h1_rdata, 32'h00220000);

    // Out of range from h0, with an in-range h1 access right behind it.
    next_cycle();
    drive0(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    #1;
    check("oor_gnt0", h0_gnt, 1'b1);
    check("oor_ramreq", ram_req, 1'b0);
    next_cycle();
    drive0(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    #1;
    check("oor_rv0", h0_rvalid, 1'b1);
    check("oor_err0", h0_err, 1'b1);
    check("oor_rdata0", h0_rdata, 32'h0);
    check("oor_rv1", h1_rvalid, 1'b0);
    check("oor_next_gnt1", h1_gnt, 1'b1);
    check("oor_next_ramreq", ram_req, 1'b1);
    next_cycle();
    idle();
    #1;
    check("oor_next_rv1", h1_rvalid, 1'b1);
    check("oor_next_err1", h1_err, 1'b0);
    check("oor_next_rdata1", h1_rdata, 32'hDEADBEEF);

    // Reset in the cycle after an h1 grant drops its response.
    next_cycle();
    drive1(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    #1;
    check("mid_gnt1", h1_gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    drive1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    #1;
    check("mid_rst_rv1", h1_rvalid, 1'b0);
    check("mid_rst_gnt0", h0_gnt, 1'b0);
    check("mid_rst_gnt1", h1_gnt, 1'b0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("mid_post_rv1", h1_rvalid, 1'b0);
    check("mid_post_gnt0", h0_gnt, 1'b1);
    check("mid_post_gnt1", h1_gnt, 1'b0);
    next_cycle();
    idle();
    #1;
    check("mid_post_rv0", h0_rvalid, 1'b1);

    // Stray RAM rvalid with nothing outstanding.
    next_cycle();
    force_rvalid = 1'b1;
    #1;
    check("stray_rv0", h0_rvalid, 1'b0);
    check("stray_rv1", h1_rvalid, 1'b0);
    force_rvalid = 1'b0;

    // Stray RAM rvalid during a local error response is ignored.
    next_cycle();
    drive0(1'b1, 1'b0, 4'hF, 32'hFFFF_FFF0, 32'h0);
    #1;
    check("stray_oor_ramreq", ram_req, 1'b0);
    next_cycle();
    idle();
    force_rvalid = 1'b1;
    #1;
    check("stray_err_rv0", h0_rvalid, 1'b1);
    check("stray_err_err0", h0_err, 1'b1);
    check("stray_err_rdata0", h0_rdata, 32'h0);
    force_rvalid = 1'b0;

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
